sp_ram_arbiter: RTL and testbench
=================================

// Module: sp_ram_arbiter
// PURPOSE
//  Shares one SyncSpRamBeNx64 instance (single-port, 64-bit, byte-enable) among NUM_PORTS requesters.
//  - Grants one access per cycle by round-robin.
//  - Zero-initialises the RAM after reset.
//  - Routes each read result back to its issuing port after the RAM read latency.
//  Sits between cache/accelerator-side request ports and the RAM macro wrapper.
// PARAMETERS
//  NUM_PORTS   2    number of requesters, 2..8
//  ADDR_WIDTH  8    RAM address width, equal to the RAM's ADDR_WIDTH
//  DATA_DEPTH  256  words to clear during init, <= 2**ADDR_WIDTH
//  OUT_REGS    0    equal to the RAM's OUT_REGS; read latency RD_LAT = 1 + OUT_REGS
// PORTS
//  Clk_CI        in   1                     clock
//  Rst_RI        in   1                     synchronous reset, active-high
//  Req_SI        in   NUM_PORTS             per-port access request
//  WrEn_SI       in   NUM_PORTS             per-port write (1) / read (0)
//  BEn_SI        in   NUM_PORTS*8           per-port byte enables; port p uses bits [8p+7:8p]
//  WrData_DI     in   NUM_PORTS*64          per-port write data
//  Addr_DI       in   NUM_PORTS*ADDR_WIDTH  per-port word address
//  Gnt_SO        out  NUM_PORTS             one-hot grant; the access is taken this cycle
//  RdValid_SO    out  NUM_PORTS             one-hot; RdData_DO belongs to this port this cycle
//  RdData_DO     out  64                    read data, shared by all ports
//  InitDone_SO   out  1                     high once RAM clearing is complete
//  RamCSel_SO    out  1                     RAM chip select
//  RamWrEn_SO    out  1                     RAM write enable
//  RamBEn_SO     out  8                     RAM byte enables
//  RamWrData_DO  out  64                    RAM write data
//  RamAddr_DO    out  ADDR_WIDTH            RAM address
//  RamRdData_DI  in   64                    RAM read data
// BEHAVIOUR
//  Reset (Rst_RI=1 at a clock edge):
//  - state=INIT, init counter=0, rr pointer=0, read pipeline cleared.
//  - Gnt_SO=0, RdValid_SO=0, InitDone_SO=0.
//  - Reset mid-operation discards every in-flight read (no RdValid is issued) and restarts init.
//  FSM INIT:
//  - Each cycle: RamCSel=1, RamWrEn=1, RamBEn=8'hFF, RamWrData=0, RamAddr=counter; counter increments.
//  - Gnt_SO=0 throughout INIT.
//  - When counter==DATA_DEPTH-1 has been written, go to SERVE. Init takes exactly DATA_DEPTH cycles.
//  FSM SERVE:
//  - InitDone_SO=1 (registered).
//  - Winner = first requesting port at or after the rr pointer, wrapping modulo NUM_PORTS.
//  - Gnt_SO is combinational from Req_SI and the pointer, so grant arrives in the same cycle as the request.
//  - The winner's WrEn, BEn, WrData and Addr drive the RAM combinationally, with RamCSel=1.
//  - No request: RamCSel=0, Ram* data outputs are don't-care, Gnt_SO=0.
//  - After a grant, pointer <= (winner+1) mod NUM_PORTS. With no grant, the pointer holds.
//  - Handshake: a requester holds Req and its operands stable until Gnt. Req may drop without a grant.
//  Reads:
//  - A granted read enters an RD_LAT-deep shift register of {valid, port id}.
//  - RdValid_SO[id] asserts exactly RD_LAT cycles after the grant, with RdData_DO = RamRdData_DI.
//  - Back-to-back reads from any ports give back-to-back RdValid pulses, in grant order.
//  - Writes produce no response.
//  - Read-after-write to the same address in consecutive cycles returns the new data; the RAM provides this.
//  - Full throughput: one access per cycle, no bubbles.
//  Other rules:
//  - RdData_DO is 0 when no RdValid_SO bit is set.
//  - Port index arithmetic uses $clog2(NUM_PORTS) bits. Wrap from NUM_PORTS-1 to 0 is explicit, not power-of-2 overflow.
// STRUCTURE
//  - Package sp_ram_arb_pkg: typedef enum logic {INIT, SERVE} arb_state_e; localparam DATA_BYTES=8; function rd_lat(out_regs).
//  - Sub-module sp_ram_rr_arb: combinational round-robin pick (Req, pointer -> one-hot Gnt, winner index).
//  - Top: FSM, init counter, pointer register, operand mux, read-tag shift register.
//  - Assertions: $onehot0(Gnt_SO); $onehot0(RdValid_SO); no Gnt while InitDone_SO=0.
// TESTING
//  T1 Init: DATA_DEPTH=256, deassert reset.
//     -> 256 writes of 0 at addresses 0..255 with BEn=FF.
//     -> InitDone_SO rises on cycle 257; no Gnt before that.
//  T2 Round-robin: NUM_PORTS=3, all Req held high for 6 cycles.
//     -> Gnt sequence 001,010,100,001,010,100.
//  T3 Read routing: port1 writes 64'hDEADBEEF_CAFEF00D to addr 5, then port0 reads addr 5.
//     -> RdValid_SO=01 with that data exactly RD_LAT cycles after the grant.
//     -> Run with OUT_REGS=0 and with OUT_REGS=1.
//  T4 Byte enables: port0 writes 64'h11..11 with BEn=8'h0F to a cleared addr, then reads it.
//     -> 64'h00000000_11111111.
//  T5 Reset mid-read: grant a read, then assert Rst_RI 1 cycle later.
//     -> No RdValid pulse, pointer=0, init restarts from address 0.
//  T6 Back-to-back reads: ports 0,1,0 read addrs 1,2,3 on consecutive cycles.
//     -> Three consecutive RdValid pulses 01,10,01 with matching data.

Source files
------------

// File: rtl/sp_ram_arbiter_pkg.sv
// sp_ram_arb_pkg: shared types, constants and latency helper for the RAM arbiter
package sp_ram_arb_pkg;
    typedef enum logic {INIT, SERVE} arb_state_e;
    localparam int DATA_BYTES = 8;
    function automatic int rd_lat(input int out_regs);
        return 1 + out_regs;
    endfunction
endpackage

// File: rtl/sp_ram_arbiter_if.sv
// sp_ram_arbiter_if: requester-side and RAM-side signals of the arbiter
interface sp_ram_arbiter_if import sp_ram_arb_pkg::*; #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 8
);
    logic [NUM_PORTS-1:0]            req, wr_en, gnt, rd_valid;
    logic [NUM_PORTS*DATA_BYTES-1:0] ben;
    logic [NUM_PORTS*64-1:0]         wr_data;
    logic [NUM_PORTS*ADDR_WIDTH-1:0] addr;
    logic [63:0]                     rd_data, ram_wr_data, ram_rd_data;
    logic                            init_done, ram_csel, ram_we;
    logic [DATA_BYTES-1:0]           ram_ben;
    logic [ADDR_WIDTH-1:0]           ram_addr;
    modport master (
        output req, wr_en, ben, wr_data, addr, ram_rd_data,
        input  gnt, rd_valid, rd_data, init_done, ram_csel, ram_we, ram_ben, ram_wr_data, ram_addr
    );
    modport slave (
        input  req, wr_en, ben, wr_data, addr, ram_rd_data,
        output gnt, rd_valid, rd_data, init_done, ram_csel, ram_we, ram_ben, ram_wr_data, ram_addr
    );
endinterface

// File: rtl/sp_ram_arbiter_rr_arb.sv
// sp_ram_rr_arb: combinational round-robin pick starting at ptr
module sp_ram_rr_arb #(
    parameter  int NUM_PORTS = 2,
    localparam int IW        = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IW-1:0]        ptr,
    output logic [NUM_PORTS-1:0] gnt,
    output logic [IW-1:0]        win,
    output logic                 any
);
    // scan from farthest to nearest so the port closest to ptr wins last
    always_comb begin
        gnt = '0;
        win = '0;
        any = |req;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % NUM_PORTS]) begin
                win = IW'((int'(ptr) + k) % NUM_PORTS);
                gnt = NUM_PORTS'(1) << win;
            end
        end
    end
endmodule

// File: rtl/sp_ram_arbiter.sv
// sp_ram_arbiter: round-robin sharing of one single-port byte-enable RAM,
// with zero-fill after reset and read-data routing back to the issuing port
module sp_ram_arbiter import sp_ram_arb_pkg::*; #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_DEPTH = 256,
    parameter int OUT_REGS   = 0
) (
    input logic             clk,
    input logic             rst,
    sp_ram_arbiter_if.slave bus
);
    localparam int IW     = $clog2(NUM_PORTS);
    localparam int RD_LAT = rd_lat(OUT_REGS);
    arb_state_e                state, state_nxt;
    logic [ADDR_WIDTH-1:0]     cnt;
    logic [IW-1:0]             ptr, win;
    logic [NUM_PORTS-1:0]      pick;
    logic                      any, serve, rd_go;
    logic [RD_LAT-1:0]         tv;
    logic [RD_LAT-1:0][IW-1:0] tid;

    sp_ram_rr_arb #(.NUM_PORTS(NUM_PORTS)) u_arb (.req(bus.req), .ptr(ptr), .gnt(pick), .win(win), .any(any));

    assign serve = state == SERVE;
    assign rd_go = serve && any && !bus.wr_en[win];

    always_comb begin
        state_nxt       = (!serve && cnt == ADDR_WIDTH'(DATA_DEPTH - 1)) ? SERVE : state;
        bus.gnt         = serve ? pick : '0;
        bus.init_done   = serve;
        bus.ram_csel    = !serve || any;
        bus.ram_we      = serve ? bus.wr_en[win] : 1'b1;
        bus.ram_ben     = serve ? bus.ben[int'(win)*DATA_BYTES +: DATA_BYTES] : '1;
        bus.ram_wr_data = serve ? bus.wr_data[int'(win)*64 +: 64] : '0;
        bus.ram_addr    = serve ? bus.addr[int'(win)*ADDR_WIDTH +: ADDR_WIDTH] : cnt;
        bus.rd_valid    = tv[RD_LAT-1] ? NUM_PORTS'(1) << tid[RD_LAT-1] : '0;
        bus.rd_data     = tv[RD_LAT-1] ? bus.ram_rd_data : '0;
    end

    // tag pipeline mirrors the RAM read latency so data and owner line up
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INIT;
            cnt   <= '0;
            ptr   <= '0;
            tv    <= '0;
            tid   <= '0;
        end else begin
            state <= state_nxt;
            if (!serve) cnt <= cnt + 1'b1;
            if (serve && any) ptr <= (win == IW'(NUM_PORTS - 1)) ? '0 : win + 1'b1;
            tv[0]  <= rd_go;
            tid[0] <= win;
            for (int i = 1; i < RD_LAT; i++) begin
                tv[i]  <= tv[i-1];
                tid[i] <= tid[i-1];
            end
        end
    end

    a_gnt_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(bus.gnt));
    a_rdv_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(bus.rd_valid));
    a_no_early:   assert property (@(posedge clk) disable iff (rst) !bus.init_done |-> bus.gnt == '0);
endmodule

// File: tb/tb_sp_ram_arbiter.sv
// tb_sp_ram_arbiter: directed and random stimulus checked against a
// behavioural model of arbitration, memory contents and read returns
module tb_sp_ram_arbiter;
    localparam int NP = 3, AW = 8, DD = 256, OR = 1, RL = 1 + OR;
    logic clk = 0, rst = 1;
    always #5 clk = ~clk;

    sp_ram_arbiter_if #(.NUM_PORTS(NP), .ADDR_WIDTH(AW)) bus();
    sp_ram_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_DEPTH(DD), .OUT_REGS(OR))
        dut (.clk(clk), .rst(rst), .bus(bus));

    // RAM macro stand-in
    logic [63:0] ram [DD];
    logic [63:0] r0, r1;
    always @(posedge clk) begin
        if (bus.ram_csel && bus.ram_we)
            for (int b = 0; b < 8; b++) if (bus.ram_ben[b]) ram[bus.ram_addr][b*8 +: 8] <= bus.ram_wr_data[b*8 +: 8];
        if (bus.ram_csel && !bus.ram_we) r0 <= ram[bus.ram_addr];
        r1 <= r0;
    end
    assign bus.ram_rd_data = (OR != 0) ? r1 : r0;

    typedef struct {int due; int port; logic [63:0] data;} rd_t;
    rd_t         q[$];
    logic [63:0] ref_mem [DD];
    logic        p_req [NP];
    logic        p_we  [NP];
    logic [7:0]  p_ben [NP];
    logic [63:0] p_dat [NP];
    logic [7:0]  p_adr [NP];
    int          rr, cyc, checks, errors;
    logic [NP-1:0] last_g, last_rv;
    logic [63:0]   last_rd;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        for (int p = 0; p < NP; p++) begin
            bus.req[p]             = p_req[p];
            bus.wr_en[p]           = p_we[p];
            bus.ben[p*8 +: 8]      = p_ben[p];
            bus.wr_data[p*64 +: 64] = p_dat[p];
            bus.addr[p*AW +: AW]   = p_adr[p];
        end
    endtask

    task automatic set_op(input int p, input logic we, input logic [7:0] ben, input logic [63:0] d, input int a);
        p_req[p] = 1'b1;
        p_we[p]  = we;
        p_ben[p] = ben;
        p_dat[p] = d;
        p_adr[p] = 8'(a);
    endtask

    task automatic idle();
        for (int p = 0; p < NP; p++) p_req[p] = 1'b0;
    endtask

    // one SERVE cycle: predict grant, apply it to the model, check returns
    task automatic cycle();
        int w;
        logic [NP-1:0] ev;
        logic [63:0] ed;
        drive();
        #1;
        w = -1;
        for (int k = 0; k < NP; k++) if (w < 0 && p_req[(rr + k) % NP]) w = (rr + k) % NP;
        last_g  = bus.gnt;
        last_rv = bus.rd_valid;
        last_rd = bus.rd_data;
        chk("gnt", bus.gnt, (w < 0) ? '0 : NP'(1) << w);
        chk("ram_csel", bus.ram_csel, w >= 0);
        if (w >= 0) begin
            chk("ram_op", {bus.ram_we, bus.ram_addr}, {p_we[w], p_adr[w]});
            if (p_we[w]) begin
                chk("ram_wr", {bus.ram_ben, bus.ram_wr_data}, {p_ben[w], p_dat[w]});
                for (int b = 0; b < 8; b++) if (p_ben[w][b]) ref_mem[p_adr[w]][b*8 +: 8] = p_dat[w][b*8 +: 8];
            end else q.push_back('{cyc + RL, w, ref_mem[p_adr[w]]});
            p_req[w] = 1'b0;
            rr = (w + 1) % NP;
        end
        ev = '0;
        ed = '0;
        if (q.size() > 0 && q[0].due == cyc) begin
            ev = NP'(1) << q[0].port;
            ed = q[0].data;
            q.delete(0);
        end
        chk("rd_valid", bus.rd_valid, ev);
        chk("rd_data", bus.rd_data, ed);
        chk("init_done", bus.init_done, 1'b1);
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_init();
        for (int i = 0; i < DD; i++) begin
            drive();
            #1;
            chk("init", {bus.ram_csel, bus.ram_we, bus.ram_ben, bus.ram_addr, bus.ram_wr_data, bus.gnt, bus.rd_valid, bus.init_done},
                {1'b1, 1'b1, 8'hFF, AW'(i), 64'h0, NP'(0), NP'(0), 1'b0});
            @(negedge clk);
        end
        for (int i = 0; i < DD; i++) ref_mem[i] = '0;
        q.delete();
        rr = 0;
    endtask

    task automatic rd_chk(input string tag, input int p, input int a, input logic [63:0] d);
        idle();
        set_op(p, 1'b0, 8'hFF, '0, a);
        cycle();
        idle();
        for (int i = 1; i <= RL; i++) begin
            cycle();
            if (i == RL) chk(tag, {last_rv, last_rd}, {NP'(1) << p, d});
            else chk({tag, "_early"}, last_rv, '0);
        end
    endtask

    initial begin
        logic [63:0] td [3];
        int tp [3];
        checks = 0; errors = 0; rr = 0; cyc = 0;
        for (int p = 0; p < NP; p++) set_op(p, 1'b0, 8'hFF, '0, p);
        drive();
        repeat (3) @(negedge clk);
        rst = 0;
        do_init();
        for (int i = 0; i < 6; i++) begin
            for (int p = 0; p < NP; p++) set_op(p, 1'b0, 8'hFF, '0, p);
            cycle();
            chk("rr_seq", last_g, NP'(1) << (i % 3));
        end
        idle();
        repeat (RL + 1) cycle();
        set_op(1, 1'b1, 8'hFF, 64'hDEADBEEF_CAFEF00D, 5);
        cycle();
        rd_chk("raw_route", 0, 5, 64'hDEADBEEF_CAFEF00D);
        idle();
        set_op(0, 1'b1, 8'h0F, 64'h11111111_11111111, 9);
        cycle();
        rd_chk("byte_en", 0, 9, 64'h00000000_11111111);
        for (int k = 0; k < 3; k++) begin
            td[k] = 64'h01234567_89ABCDEF ^ (64'(k + 1) * 64'h11110000_0000FFFF);
            idle();
            set_op(2, 1'b1, 8'hFF, td[k], k + 1);
            cycle();
        end
        tp = '{0, 1, 0};
        for (int j = 0; j < 3 + RL; j++) begin
            idle();
            if (j < 3) set_op(tp[j], 1'b0, 8'hFF, '0, j + 1);
            cycle();
            if (j >= RL) chk("b2b", {last_rv, last_rd}, {NP'(1) << tp[j-RL], td[j-RL]});
        end
        idle();
        set_op(0, 1'b0, 8'hFF, '0, 7);
        cycle();
        idle();
        drive();
        rst = 1;
        #1;
        chk("rst_rdv", bus.rd_valid, '0);
        @(negedge clk);
        rst = 0;
        do_init();
        for (int p = 0; p < NP; p++) set_op(p, 1'b0, 8'hFF, '0, p);
        cycle();
        chk("rst_ptr", last_g, NP'(1));
        for (int n = 0; n < 1500; n++) begin
            for (int p = 0; p < NP; p++) begin
                if (!p_req[p] && $urandom_range(1, 0) == 1)
                    set_op(p, 1'($urandom), 8'($urandom), {$urandom, $urandom}, int'($urandom_range(15, 0)));
                else if (p_req[p] && $urandom_range(15, 0) == 0)
                    p_req[p] = 1'b0;
            end
            cycle();
        end
        idle();
        repeat (RL + 1) cycle();
        chk("drain", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
